// File: rtl/zxuno_regport.sv
// CPU front end of the ZXUNO register file: decodes the address/data I/O ports,
// holds the current register number and returns peripheral read data to the CPU.
module zxuno_regport #(
    parameter logic [15:0] ADDR_PORT = 16'hFC3B,
    parameter logic [15:0] DATA_PORT = 16'hFD3B,
    parameter logic [7:0]  IDLE_BYTE = 8'hFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] a,
    input  logic        iorq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  dout,
    output logic        oe,
    output logic [7:0]  zxuno_addr,
    output logic        zxuno_regrd,
    output logic        zxuno_regwr,
    output logic [7:0]  zxuno_wrdata,
    output logic        regaddr_changed,
    input  logic [7:0]  periph_dout,
    input  logic        periph_oe
);

    logic [15:0] a_q;
    logic        iorq_n_q;
    logic        rd_n_q;
    logic        wr_n_q;
    logic [7:0]  cpu_dout_q;
    logic        wr_prev;

    logic rd_acc;
    logic wr_acc;
    logic wr_raw;
    logic wr_commit;
    logic hit_addr;
    logic hit_data;

    always_comb begin
        rd_acc    = !iorq_n_q && !rd_n_q;
        wr_acc    = !iorq_n_q && !wr_n_q && rd_n_q;
        wr_raw    = !iorq_n && !wr_n && rd_n;
        wr_commit = wr_acc && !wr_prev;
        hit_addr  = (a_q == ADDR_PORT);
        hit_data  = (a_q == DATA_PORT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q             <= 16'h0000;
            iorq_n_q        <= 1'b1;
            rd_n_q          <= 1'b1;
            wr_n_q          <= 1'b1;
            cpu_dout_q      <= 8'h00;
            wr_prev         <= 1'b1;
            zxuno_addr      <= 8'h00;
            zxuno_wrdata    <= 8'h00;
            zxuno_regwr     <= 1'b0;
            zxuno_regrd     <= 1'b0;
            regaddr_changed <= 1'b0;
            dout            <= 8'h00;
            oe              <= 1'b0;
        end else begin
            a_q        <= a;
            iorq_n_q   <= iorq_n;
            rd_n_q     <= rd_n;
            wr_n_q     <= wr_n;
            cpu_dout_q <= cpu_dout;

            // Stay armed-off while a write that straddled reset is still on the raw bus,
            // since the reset-loaded stage-0 copies would otherwise look like a release.
            wr_prev <= wr_acc || (wr_prev && wr_raw);

            regaddr_changed <= 1'b0;
            zxuno_regwr     <= 1'b0;
            if (wr_commit && hit_addr) begin
                zxuno_addr      <= cpu_dout_q;
                regaddr_changed <= 1'b1;
            end
            if (wr_commit && hit_data) begin
                zxuno_wrdata <= cpu_dout_q;
                zxuno_regwr  <= 1'b1;
            end

            zxuno_regrd <= rd_acc && hit_data;

            if (rd_acc && hit_addr) begin
                oe   <= 1'b1;
                dout <= zxuno_addr;
            end else if (rd_acc && hit_data) begin
                oe   <= 1'b1;
                dout <= periph_oe ? periph_dout : IDLE_BYTE;
            end else begin
                oe <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_zxuno_regport.sv
// Self-checking bench for zxuno_regport: directed scenarios plus randomized
// accesses checked against a transaction-level model of the register port.
module tb_zxuno_regport;

    localparam logic [15:0] AP = 16'hFC3B;
    localparam logic [15:0] DP = 16'hFD3B;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] a = 16'h0000;
    logic        iorq_n = 1'b1;
    logic        rd_n = 1'b1;
    logic        wr_n = 1'b1;
    logic [7:0]  cpu_dout = 8'h00;
    logic [7:0]  dout;
    logic        oe;
    logic [7:0]  zxuno_addr;
    logic        zxuno_regrd;
    logic        zxuno_regwr;
    logic [7:0]  zxuno_wrdata;
    logic        regaddr_changed;
    logic [7:0]  periph_dout = 8'h00;
    logic        periph_oe = 1'b0;

    int checks = 0;
    int failures = 0;

    // Model state
    logic [7:0] m_addr = 8'h00;
    logic [7:0] m_wrdata = 8'h00;
    logic [7:0] m_dout = 8'h00;

    zxuno_regport dut (
        .clk            (clk),
        .rst            (rst),
        .a              (a),
        .iorq_n         (iorq_n),
        .rd_n           (rd_n),
        .wr_n           (wr_n),
        .cpu_dout       (cpu_dout),
        .dout           (dout),
        .oe             (oe),
        .zxuno_addr     (zxuno_addr),
        .zxuno_regrd    (zxuno_regrd),
        .zxuno_regwr    (zxuno_regwr),
        .zxuno_wrdata   (zxuno_wrdata),
        .regaddr_changed(regaddr_changed),
        .periph_dout    (periph_dout),
        .periph_oe      (periph_oe)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // One CPU cycle held for len clocks, then idle; observations over len+4 samples.
    task automatic access(input logic [15:0] addr, input bit io, input bit rd, input bit wr,
                          input logic [7:0] data, input int len,
                          output int n_chg, output int n_wr, output int n_rd, output int n_oe,
                          output int first_rd, output int first_chg,
                          output logic [7:0] oe_dout, output logic [7:0] chg_addr);
        n_chg = 0; n_wr = 0; n_rd = 0; n_oe = 0;
        first_rd = -1; first_chg = -1;
        oe_dout = 8'h00; chg_addr = 8'h00;
        @(negedge clk);
        a = addr; iorq_n = !io; rd_n = !rd; wr_n = !wr; cpu_dout = data;
        for (int i = 1; i <= len + 4; i++) begin
            @(negedge clk);
            if (regaddr_changed) begin
                if (first_chg < 0) begin first_chg = i; chg_addr = zxuno_addr; end
                n_chg++;
            end
            if (zxuno_regwr) n_wr++;
            if (zxuno_regrd) begin
                if (first_rd < 0) first_rd = i;
                n_rd++;
            end
            if (oe) begin
                if (n_oe == 0) oe_dout = dout;
                n_oe++;
            end
            if (i == len) begin iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; end
        end
    endtask

    task automatic test_reset();
        int nc, nw, nr, no, fr, fc;
        logic [7:0] od, ca;
        @(negedge clk);
        rst = 1'b1; a = AP; iorq_n = 1'b0; wr_n = 1'b0; rd_n = 1'b1; cpu_dout = 8'h42;
        repeat (3) @(negedge clk);
        checks++; if ({zxuno_addr, zxuno_wrdata, dout} !== 24'h0) begin failures++;
            $display("FAIL reset_regs: got %h %h %h want 00 00 00",
                     zxuno_addr, zxuno_wrdata, dout); end
        checks++; if ({oe, zxuno_regrd, zxuno_regwr, regaddr_changed} !== 4'b0) begin failures++;
            $display("FAIL reset_flags: got %b want 0000",
                     {oe, zxuno_regrd, zxuno_regwr, regaddr_changed}); end
        rst = 1'b0;
        nc = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (regaddr_changed) nc++;
        end
        checks++; if (nc !== 0) begin failures++;
            $display("FAIL reset_straddle_pulse: got %0d pulses want 0", nc); end
        checks++; if (zxuno_addr !== 8'h00) begin failures++;
            $display("FAIL reset_straddle_addr: got %h want 00", zxuno_addr); end
        iorq_n = 1'b1; wr_n = 1'b1;
        repeat (3) @(negedge clk);
        access(AP, 1, 0, 1, 8'h42, 2, nc, nw, nr, no, fr, fc, od, ca);
        m_addr = 8'h42;
        checks++; if (nc !== 1 || fc !== 2) begin failures++;
            $display("FAIL reset_fresh_pulse: got %0d pulses at %0d want 1 at 2", nc, fc); end
        checks++; if (ca !== 8'h42) begin failures++;
            $display("FAIL reset_fresh_same_cycle: addr at pulse %h want 42", ca); end
    endtask

    task automatic test_addr_write();
        int nc, nw, nr, no, fr, fc;
        logic [7:0] od, ca;
        for (int k = 0; k < 2; k++) begin
            access(AP, 1, 0, 1, 8'hFF, 6, nc, nw, nr, no, fr, fc, od, ca);
            m_addr = 8'hFF;
            checks++; if (nc !== 1) begin failures++;
                $display("FAIL addr_write_pulse[%0d]: got %0d want 1", k, nc); end
            checks++; if (zxuno_addr !== 8'hFF || nw !== 0) begin failures++;
                $display("FAIL addr_write_value[%0d]: got %h regwr=%0d want FF 0",
                         k, zxuno_addr, nw); end
        end
    endtask

    task automatic test_data_write();
        int nc, nw, nr, no, fr, fc;
        logic [7:0] od, ca;
        access(AP, 1, 0, 1, 8'h33, 2, nc, nw, nr, no, fr, fc, od, ca);
        m_addr = 8'h33;
        access(DP, 1, 0, 1, 8'h5A, 8, nc, nw, nr, no, fr, fc, od, ca);
        m_wrdata = 8'h5A;
        checks++; if (nw !== 1 || nc !== 0) begin failures++;
            $display("FAIL data_write_pulse: got regwr=%0d chg=%0d want 1 0", nw, nc); end
        checks++; if (zxuno_wrdata !== 8'h5A || zxuno_addr !== 8'h33) begin failures++;
            $display("FAIL data_write_value: got wrdata=%h addr=%h want 5A 33",
                     zxuno_wrdata, zxuno_addr); end
    endtask

    task automatic test_read_claimed();
        int nc, nw, nr, no, fr, fc;
        logic [7:0] od, ca;
        periph_oe = 1'b1; periph_dout = 8'h43;
        access(DP, 1, 1, 0, 8'h00, 4, nc, nw, nr, no, fr, fc, od, ca);
        m_dout = 8'h43;
        checks++; if (nr !== 4 || no !== 4 || fr !== 2) begin failures++;
            $display("FAIL read_claimed_timing: got regrd=%0d oe=%0d first=%0d want 4 4 2",
                     nr, no, fr); end
        checks++; if (od !== 8'h43 || dout !== 8'h43) begin failures++;
            $display("FAIL read_claimed_data: got %h/%h want 43", od, dout); end
    endtask

    task automatic test_back_to_back();
        int periods, high;
        logic prev;
        periods = 0; high = 0; prev = 1'b0;
        periph_oe = 1'b1; periph_dout = 8'h43;
        @(negedge clk);
        a = DP; iorq_n = 1'b0; rd_n = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (zxuno_regrd) high++;
            if (zxuno_regrd && !prev) periods++;
            prev = zxuno_regrd;
            iorq_n = !((i < 3) || (i >= 4 && i < 7));
            rd_n = iorq_n;
        end
        checks++; if (periods !== 2 || high !== 6) begin failures++;
            $display("FAIL back_to_back_reads: got %0d periods %0d high want 2 6",
                     periods, high); end
    endtask

    task automatic test_unclaimed_and_addr_read();
        int nc, nw, nr, no, fr, fc;
        logic [7:0] od, ca;
        periph_oe = 1'b0; periph_dout = 8'h77;
        access(DP, 1, 1, 0, 8'h00, 3, nc, nw, nr, no, fr, fc, od, ca);
        checks++; if (od !== 8'hFF || no !== 3) begin failures++;
            $display("FAIL unclaimed_read: got %h oe=%0d want FF 3", od, no); end
        access(AP, 1, 0, 1, 8'h0F, 2, nc, nw, nr, no, fr, fc, od, ca);
        m_addr = 8'h0F;
        access(AP, 1, 1, 0, 8'h00, 3, nc, nw, nr, no, fr, fc, od, ca);
        m_dout = 8'h0F;
        checks++; if (od !== 8'h0F || no !== 3 || nr !== 0) begin failures++;
            $display("FAIL addr_read: got %h oe=%0d regrd=%0d want 0F 3 0", od, no, nr); end
    endtask

    task automatic test_decode_exact();
        int nc, nw, nr, no, fr, fc;
        logic [7:0] od, ca;
        logic [15:0] miss [3];
        miss[0] = 16'hFC3A; miss[1] = 16'hFD3C; miss[2] = 16'hBD3B;
        for (int k = 0; k < 3; k++) begin
            access(miss[k], 1, 0, 1, 8'hA5, 3, nc, nw, nr, no, fr, fc, od, ca);
            checks++; if (nc !== 0 || nw !== 0) begin failures++;
                $display("FAIL decode_wr_%h: got chg=%0d regwr=%0d want 0 0", miss[k], nc, nw); end
            access(miss[k], 1, 1, 0, 8'h00, 3, nc, nw, nr, no, fr, fc, od, ca);
            checks++; if (no !== 0 || nr !== 0) begin failures++;
                $display("FAIL decode_rd_%h: got oe=%0d regrd=%0d want 0 0", miss[k], no, nr); end
        end
        access(AP, 0, 0, 1, 8'hA5, 3, nc, nw, nr, no, fr, fc, od, ca);
        checks++; if (nc !== 0 || no !== 0 || zxuno_addr !== m_addr) begin failures++;
            $display("FAIL decode_memwr: got chg=%0d oe=%0d addr=%h want 0 0 %h",
                     nc, no, zxuno_addr, m_addr); end
        periph_oe = 1'b1; periph_dout = 8'h3C;
        access(DP, 1, 1, 1, 8'hA5, 3, nc, nw, nr, no, fr, fc, od, ca);
        m_dout = 8'h3C;
        checks++; if (nw !== 0 || nr !== 3 || od !== 8'h3C) begin failures++;
            $display("FAIL decode_rdwr: got regwr=%0d regrd=%0d dout=%h want 0 3 3C",
                     nw, nr, od); end
    endtask

    task automatic test_random();
        int nc, nw, nr, no, fr, fc, len;
        logic [7:0] od, ca, data, exp_rd_byte;
        logic [15:0] addr;
        bit io, rd, wr, is_rd, is_wr, to_a, to_d;
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(5))
                0: addr = AP;
                1: addr = DP;
                2: addr = AP ^ 16'h0001;
                3: addr = DP + 16'h0100;
                4: addr = 16'(($urandom_range(255) << 8) | 32'h3B);
                default: addr = 16'($urandom());
            endcase
            io = ($urandom_range(4) != 0);
            rd = $urandom_range(1) == 1;
            wr = $urandom_range(1) == 1;
            data = 8'($urandom());
            len = $urandom_range(6, 1);
            periph_oe = $urandom_range(1) == 1;
            periph_dout = 8'($urandom());
            // Model: a CPU I/O cycle is a read whenever RD is low, a write only otherwise.
            is_rd = io && rd;
            is_wr = io && wr && !rd;
            to_a = (addr == AP);
            to_d = (addr == DP);
            exp_rd_byte = to_a ? m_addr : (periph_oe ? periph_dout : 8'hFF);
            access(addr, io, rd, wr, data, len, nc, nw, nr, no, fr, fc, od, ca);
            if (is_wr && to_a) m_addr = data;
            if (is_wr && to_d) m_wrdata = data;
            if (is_rd && (to_a || to_d)) m_dout = exp_rd_byte;
            checks++; if (nc !== int'(is_wr && to_a) || nw !== int'(is_wr && to_d)) begin
                failures++;
                $display("FAIL rand%0d_pulses a=%h: got chg=%0d wr=%0d want %0d %0d", n, addr,
                         nc, nw, int'(is_wr && to_a), int'(is_wr && to_d)); end
            checks++; if (nr !== ((is_rd && to_d) ? len : 0)
                          || no !== ((is_rd && (to_a || to_d)) ? len : 0)) begin
                failures++;
                $display("FAIL rand%0d_read_len a=%h: got regrd=%0d oe=%0d len=%0d",
                         n, addr, nr, no, len); end
            checks++; if (zxuno_addr !== m_addr || zxuno_wrdata !== m_wrdata
                          || dout !== m_dout) begin
                failures++;
                $display("FAIL rand%0d_state: got %h %h %h want %h %h %h", n, zxuno_addr,
                         zxuno_wrdata, dout, m_addr, m_wrdata, m_dout); end
            if (is_rd && (to_a || to_d)) begin
                checks++; if (od !== exp_rd_byte) begin failures++;
                    $display("FAIL rand%0d_rdata: got %h want %h", n, od, exp_rd_byte); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_addr_write();
        test_data_write();
        test_read_claimed();
        test_back_to_back();
        test_unclaimed_and_addr_read();
        test_decode_exact();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
